// File: rtl/urx_pkg.sv
// Shared constants for the UART receive path: the bit timing used by the
// receiver and the default depth of the receive byte FIFO.
package urx_pkg;

  localparam int URX_CLK_HZ       = 25_000_000;
  localparam int URX_BAUD         = 115_200;
  localparam int URX_CLKS_PER_BIT = URX_CLK_HZ / URX_BAUD;

  localparam int URX_FIFO_DEPTH   = 16;
  localparam int URX_BYTE_W       = 8;

  typedef logic [URX_BYTE_W-1:0] urx_byte_t;

endpackage

// File: rtl/urx_fifo_ram.sv
// Byte storage for the receive FIFO: synchronous write port and an
// asynchronous read port, so the head entry is visible combinationally.
module urx_fifo_ram
  import urx_pkg::*;
#(
  parameter int DEPTH  = URX_FIFO_DEPTH,
  parameter int DATA_W = URX_BYTE_W,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic              i_Clock,
  input  logic              i_Wr_En,
  input  logic [AW-1:0]     i_Wr_Addr,
  input  logic [DATA_W-1:0] i_Wr_Data,
  input  logic [AW-1:0]     i_Rd_Addr,
  output logic [DATA_W-1:0] o_Rd_Data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming byte into the addressed entry; contents are not reset.
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = mem[i_Rd_Addr];

endmodule

// File: rtl/urx_fifo.sv
// Receive-side first-word-fall-through byte FIFO behind the UART receiver.
// Pointers carry an extra wrap bit so full and empty are told apart without
// a separate counter; bytes arriving while full and not draining are dropped
// and recorded in a sticky overrun flag.
module urx_fifo
  import urx_pkg::*;
#(
  parameter int DEPTH = URX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
)(
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [7:0]  o_Data,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [AW:0] o_Count,
  output logic        o_Full,
  output logic        o_Empty,
  output logic        o_Overrun,
  input  logic        i_Clr_Overrun
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic [7:0]  rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot being written, so a full FIFO still accepts a byte
  // when the consumer drains in the same cycle.
  assign pop  = ~empty & i_Ready;
  assign push = i_Rx_DV & (~full | pop);
  assign drop = i_Rx_DV & full & ~pop;

  urx_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_ram (
    .i_Clock   (i_Clock),
    .i_Wr_En   (push),
    .i_Wr_Addr (wr_ptr[AW-1:0]),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (rd_ptr[AW-1:0]),
    .o_Rd_Data (rd_data)
  );

  // Advance write/read pointers on accepted pushes and pops; wrap is natural.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overrun: a dropped byte wins over a clear in the same cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Overrun <= 1'b0;
    end else if (drop) begin
      o_Overrun <= 1'b1;
    end else if (i_Clr_Overrun) begin
      o_Overrun <= 1'b0;
    end
  end

  // Stale storage is masked while empty so the output reads zero after reset.
  assign o_Data  = empty ? 8'h00 : rd_data;
  assign o_Valid = ~empty;
  assign o_Count = wr_ptr - rd_ptr;
  assign o_Full  = full;
  assign o_Empty = empty;

endmodule

// File: tb/tb_urx_fifo.sv
// Bench for urx_fifo: a queue-based model tracks the expected contents and
// overrun flag; every falling edge the DUT outputs are compared against it.
// Directed sequences add literal expectations that pin the model itself.
module tb_urx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          ready = 1'b0;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_overrun;
  logic          clr_ovr = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  urx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Data        (o_data),
    .o_Valid       (o_valid),
    .i_Ready       (ready),
    .o_Count       (o_count),
    .o_Full        (o_full),
    .o_Empty       (o_empty),
    .o_Overrun     (o_overrun),
    .i_Clr_Overrun (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of stored bytes plus the sticky flag.
  logic [7:0] mq[$];
  bit         mov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      bit do_pop, is_full, take, lost;
      do_pop  = (mq.size() > 0) && ready;
      is_full = (mq.size() == DEPTH);
      take    = rx_dv && (!is_full || do_pop);
      lost    = rx_dv && is_full && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (take) mq.push_back(rx_byte);
      if (lost) mov = 1'b1;
      else if (clr_ovr) mov = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid",   32'(o_valid),   32'(mq.size() > 0));
      chk("m_data",    32'(o_data),    (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      chk("m_count",   32'(o_count),   32'(mq.size()));
      chk("m_full",    32'(o_full),    32'(mq.size() == DEPTH));
      chk("m_empty",   32'(o_empty),   32'(mq.size() == 0));
      chk("m_overrun", 32'(o_overrun), 32'(mov));
    end
  end

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic cyc(input logic dv, input logic [7:0] b, input logic rdy, input logic clr);
    rx_dv   = dv;
    rx_byte = b;
    ready   = rdy;
    clr_ovr = clr;
    @(negedge clk);
  endtask

  initial begin
    int next_exp;
    int sent;

    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Idle after reset
    repeat (5) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_empty", 32'(o_empty), 32'd1);
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_count", 32'(o_count), 32'd0);
      chk("idle_ovr",   32'(o_overrun), 32'd0);
      chk("idle_data",  32'(o_data), 32'h00);
    end

    // Single byte
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_valid", 32'(o_valid), 32'd1);
    chk("single_data",  32'(o_data), 32'hA5);
    chk("single_count", 32'(o_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", 32'(o_empty), 32'd1);

    // Fill and overflow with 17 bytes
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  32'(o_full), 32'd1);
    chk("fill_count", 32'(o_count), 32'd16);
    chk("fill_ovr",   32'(o_overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(o_valid), 32'd1);
      chk("drain_data",  32'(o_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(o_empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovr", 32'(o_overrun), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("pp_full", 32'(o_full), 32'd1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_count", 32'(o_count), 32'd16);
    chk("pp_ovr",   32'(o_overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk("pp_drain", 32'(o_data), 32'(8'h20 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_last", 32'(o_data), 32'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_empty", 32'(o_empty), 32'd1);

    // Wrap-around stream of 40 bytes with consumer ready every other cycle
    next_exp = 0;
    sent     = 0;
    for (int c = 0; c < 100; c++) begin
      logic dv, rdy;
      dv  = (c % 2 == 0) && (sent < 40);
      rdy = (c % 2 == 1);
      if (rdy && o_valid) begin
        chk("wrap_order", 32'(o_data), 32'(8'(8'hC0 + next_exp)));
        next_exp++;
      end
      cyc(dv, 8'(8'hC0 + sent), rdy, 1'b0);
      if (dv) sent++;
    end
    chk("wrap_total", 32'(next_exp), 32'd40);
    chk("wrap_ovr",   32'(o_overrun), 32'd0);

    // Overrun set beats clear; clear alone works
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("prio_ovr", 32'(o_overrun), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("prio_clr", 32'(o_overrun), 32'd0);

    // Reset mid-fill takes effect before the next clock edge
    repeat (16) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("rst_pre_count", 32'(o_count), 32'd5);
    rx_dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_count", 32'(o_count), 32'd0);
    chk("rst_async_valid", 32'(o_valid), 32'd0);
    chk("rst_async_data",  32'(o_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_empty", 32'(o_empty), 32'd1);

    // Randomized traffic biased to reach full and overflow
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 5));
    end
    for (int c = 0; c < 20; c++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_empty", 32'(o_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/urx_fifo.md
# urx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each byte presented with the receiver's one-cycle data-valid strobe into a first-word-fall-through FIFO, and presents bytes to the consumer over a valid/ready handshake. Absorbs bursts while the consumer is busy, and flags bytes lost to overflow with a sticky overrun bit.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2.
- AW, $clog2(DEPTH): pointer index width; derived, not overridden.

- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Rx_DV  in  1  one-cycle strobe from the receiver: byte valid.
- i_Rx_Byte  in  8  received byte, qualified by i_Rx_DV.
- o_Data  out  8  head-of-FIFO byte, valid when o_Valid=1.
- o_Valid  out  1  FIFO non-empty; o_Data holds a byte.
- i_Ready  in  1  consumer accepts o_Data this cycle.
- o_Count  out  AW+1  number of stored bytes, 0..DEPTH.
- o_Full  out  1  o_Count == DEPTH.
- o_Empty  out  1  o_Count == 0.
- o_Overrun  out  1  sticky: at least one byte was dropped.
- i_Clr_Overrun  in  1  synchronous clear of o_Overrun.

## Operation
- Storage: DEPTH×8 array.
- Write pointer wr_ptr and read pointer rd_ptr are AW+1 bits each.
- Array is indexed with the low AW bits; the MSB is the wrap bit.
- Count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Full: pointers have equal index bits and different MSBs. Empty: pointers are equal.
- push = i_Rx_DV & (~o_Full | pop). pop = o_Valid & i_Ready.
- On push: mem[wr_ptr] ← i_Rx_Byte, then wr_ptr increments.
- On pop: rd_ptr increments.
- Pointer increments wrap naturally from DEPTH·2−1 to 0.
- Full with simultaneous pop and i_Rx_DV: the write is accepted, count stays DEPTH, and no overrun is flagged.
- Full with i_Rx_DV and no pop: the byte is discarded, pointers are unchanged, and o_Overrun←1.
- Empty with i_Ready=1: no pop occurs, and rd_ptr is unchanged.
- Empty with i_Rx_DV: the byte is written and becomes visible on the next cycle. No same-cycle bypass.
- Overrun: set takes priority over i_Clr_Overrun in the same cycle. Otherwise i_Clr_Overrun=1 clears it.
- i_Rx_Byte is ignored when i_Rx_DV=0.

## Timing
- Reset (async assert, sync-safe deassert by the system) gives:
  - wr_ptr=0, rd_ptr=0
  - o_Valid=0, o_Empty=1, o_Full=0, o_Count=0, o_Overrun=0
  - o_Data=8'h00, because the array is cleared, or the output is masked to 0 while empty.
- Reset mid-operation discards all stored bytes immediately. Outputs take their reset values asynchronously.
- Write-to-visible latency is 1 cycle: a push at edge N gives o_Valid=1 and o_Data=byte after edge N.
- o_Data is a combinational read of mem[rd_ptr[AW-1:0]] from registered storage. It is stable while o_Valid=1 and i_Ready=0.
- A pop at edge N presents the next byte, or o_Valid=0, after edge N.
- o_Count, o_Full and o_Empty are registered-pointer derived and update 1 cycle after the causing edge.
- Back-to-back i_Rx_DV on consecutive cycles must be supported, even though the receiver cannot produce this.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package urx_pkg holds:
  - baud-rate clock-per-bit constants, also used by the receiver
  - default RX FIFO depth constant URX_FIFO_DEPTH = 16
- One sub-module, urx_fifo_ram: DEPTH×8 storage with synchronous write port and asynchronous read port.
- Pointer, flag and overrun logic stay in urx_fifo.

## Test plan
- Reset then idle, with i_Ready=0 and no i_Rx_DV → o_Empty=1, o_Valid=0, o_Count=0, o_Overrun=0 indefinitely.
- Single byte, with i_Rx_DV pulsed and i_Rx_Byte=8'hA5 and i_Ready=0:
  - → next cycle o_Valid=1, o_Data=8'hA5, o_Count=1.
  - Then i_Ready=1 for 1 cycle → o_Empty=1.
- Fill and overflow (DEPTH=16), with i_Ready=0 and bytes 8'h00..8'h10 pushed (17 bytes):
  - → o_Full=1, o_Count=16, o_Overrun=1.
  - Drain yields 8'h00..8'h0F in order, and 8'h10 is absent.
- Full with simultaneous push/pop: at Full, i_Rx_DV=1 with 8'h55 and i_Ready=1 in the same cycle:
  - → o_Count stays 16, o_Overrun stays 0.
  - 8'h55 emerges last on drain.
- Wrap-around: 40 bytes streamed with i_Ready toggling 1-of-2 cycles → all 40 bytes are output in order, with no loss and no overrun.
- Overrun priority and reset mid-fill:
  - i_Clr_Overrun=1 in the same cycle as a dropped byte → o_Overrun=1.
  - i_Clr_Overrun=1 alone → o_Overrun=0.
  - i_Rst_n=0 with 5 bytes stored → o_Count=0 and o_Valid=0 immediately, before the next clock edge.
